cu_xb_pipe: RTL and testbench
=============================

// Module: cu_xb_pipe
// PURPOSE
//  Parametrised, pipelined successor of the compute-unit crossbar between NUM_CU compute units plus broadcast and the register file.
//  Selects one write-back source per cycle and registers it in a one-stage write-back (WB) register that drives the RF write port.
//  Forwards both the incoming result and the WB-stage result to NUM_RD read ports, flags source collisions, and sits between the CUs and the RF.
// PARAMETERS
//  DATA_WIDTH     16  datapath width
//  ADDRESS_WIDTH  4   RF address width
//  NUM_CU         3   compute units (index 0=ALU, 1=MUL, 2=SHF, higher=extra CUs)
//  NUM_RD         2   RF read ports (0=x, 1=y, ...)
// PORTS
//  clk            in   1                clock, all state on rising edge
//  reset          in   1                synchronous, active-high reset
//  ps_xb_w_cuEn   in   NUM_CU           per-CU write request, bit i = CU i
//  ps_xb_w_bcEn   in   1                broadcast write request
//  ps_xb_wadd     in   ADDRESS_WIDTH    destination RF address of this cycle's write
//  cu_xb_dt       in   NUM_CU*DW        CU results, CU i at [i*DW +: DW]
//  bc_dt          in   DATA_WIDTH       broadcast data
//  ps_xb_radd     in   NUM_RD*AW        read addresses, port r at [r*AW +: AW]
//  rf_xb_dt       in   NUM_RD*DW        raw RF read data per port
//  xb_dt          out  NUM_RD*DW        forwarded operand data per port
//  xb_rf_w_En     out  1                registered RF write enable
//  xb_rf_wadd     out  ADDRESS_WIDTH    registered RF write address
//  xb_rf_dt       out  DATA_WIDTH       registered RF write data
//  xb_coll        out  1                1-cycle pulse: more than one request this cycle
//  xb_coll_stky   out  1                sticky collision flag, cleared only by reset
// BEHAVIOUR
//  - Reset, synchronous: xb_rf_w_En=0, xb_rf_wadd=0, xb_rf_dt=0, xb_coll=0, xb_coll_stky=0, collision counter=0.
//    Reset wins over any same-cycle request; the request is dropped and produces no WB entry.
//  - Request: req = |ps_xb_w_cuEn | ps_xb_w_bcEn.
//  - Source select is fixed priority: bc > CU0 > CU1 > ... > CU(NUM_CU-1). The winner's data is sel_dt.
//  - WB stage, 1-cycle latency, loaded every cycle:
//    xb_rf_w_En <= req; xb_rf_wadd <= ps_xb_wadd; xb_rf_dt <= req ? sel_dt : 0.
//    The RF commits on the edge after the WB stage holds the value.
//  - Collision: popcount({cuEn,bcEn}) > 1. Then xb_coll=1 on the next cycle (registered), xb_coll_stky<=1, and the winner is still written.
//  - Forwarding per port r, combinational, in priority order:
//    1. req & radd[r]==ps_xb_wadd -> sel_dt (youngest)
//    2. else xb_rf_w_En & radd[r]==xb_rf_wadd -> xb_rf_dt
//    3. else rf_xb_dt[r]
//  - Same address in both the incoming request and the WB stage: the incoming value wins. Back-to-back writes to one address forward the newest.
//  - Any number of read ports may match at once; each resolves independently.
//  - No request: outputs remain a pure RF pass-through one cycle after the last write.
// CONFIGURATION
//  - Macro XB_COLL_CNT_EN defined: adds output xb_coll_cnt [15:0].
//    Increments by 1 on each collision cycle, saturates at 16'hFFFF, reset to 0.
//  - Macro not defined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package cu_xb_pkg: source-index constants (SRC_BC, SRC_ALU=0, SRC_MUL=1, SRC_SHF=2) and the collision-counter width constant (16).
//  - Sub-module cu_xb_fwd: one read port's 3-way forwarding mux. Instantiated NUM_RD times in a generate loop.
//  - Top level holds the priority selector, the WB register, the collision logic and the optional counter.
// TESTING
//  1. Reset high with cuEn=3'b001 -> xb_rf_w_En=0, xb_rf_dt=0, and after reset deasserts no write appears.
//  2. cuEn=3'b010, wadd=5, mul data=16'hBEEF
//     -> next cycle xb_rf_w_En=1, xb_rf_wadd=5, xb_rf_dt=16'hBEEF; the cycle after, w_En=0.
//  3. Cycle t: ALU writes 16'h1111 to reg 3, with radd0=3 and radd1=3 -> both ports =16'h1111 in cycle t.
//     Cycle t+1, no request -> still 16'h1111 (WB forward), RF data ignored.
//  4. t: ALU writes 16'hAAAA to reg 7; t+1: SHF writes 16'h5555 to reg 7, radd0=7
//     -> port0=16'h5555 in t+1; WB commits AAAA then 5555.
//  5. bcEn=1 and cuEn=3'b101 with bc_dt=16'h00C3
//     -> winner bc: xb_rf_dt=16'h00C3, xb_coll pulses, stky=1 until reset, counter (if enabled)=1.
//  6. Counter preloaded to 16'hFFFE via forced collisions (enabled build) -> reaches FFFF and holds there.

Source files
------------

// File: rtl/cu_xb_pkg.sv
// cu_xb_pkg: source indices and collision-counter width shared by the crossbar files
package cu_xb_pkg;
    localparam int SRC_BC     = -1;
    localparam int SRC_ALU    = 0;
    localparam int SRC_MUL    = 1;
    localparam int SRC_SHF    = 2;
    localparam int COLL_CNT_W = 16;
endpackage

// File: rtl/cu_xb_fwd.sv
// cu_xb_fwd: one read port's forwarding mux, youngest write first, then WB stage, then RF
module cu_xb_fwd
    import cu_xb_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic [AW-1:0] radd,
    input  logic          req,
    input  logic [AW-1:0] wadd,
    input  logic [DW-1:0] sel_dt,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_wadd,
    input  logic [DW-1:0] wb_dt,
    input  logic [DW-1:0] rf_dt,
    output logic [DW-1:0] dt
);
    // incoming write beats the WB stage when both hit the same address
    always_comb dt = (req && radd == wadd) ? sel_dt : (wb_en && radd == wb_wadd) ? wb_dt : rf_dt;
endmodule

// File: rtl/cu_xb_pipe.sv
// cu_xb_pipe: pipelined CU/broadcast crossbar into the RF with forwarding; XB_COLL_CNT_EN adds a collision counter
module cu_xb_pipe
    import cu_xb_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_CU        = 3,
    parameter int NUM_RD        = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CU-1:0]               ps_xb_w_cuEn,
    input  logic                            ps_xb_w_bcEn,
    input  logic [ADDRESS_WIDTH-1:0]        ps_xb_wadd,
    input  logic [NUM_CU*DATA_WIDTH-1:0]    cu_xb_dt,
    input  logic [DATA_WIDTH-1:0]           bc_dt,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] ps_xb_radd,
    input  logic [NUM_RD*DATA_WIDTH-1:0]    rf_xb_dt,
    output logic [NUM_RD*DATA_WIDTH-1:0]    xb_dt,
    output logic                            xb_rf_w_En,
    output logic [ADDRESS_WIDTH-1:0]        xb_rf_wadd,
    output logic [DATA_WIDTH-1:0]           xb_rf_dt,
    output logic                            xb_coll,
    output logic                            xb_coll_stky
`ifdef XB_COLL_CNT_EN
    ,
    output logic [COLL_CNT_W-1:0]           xb_coll_cnt
`endif
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDRESS_WIDTH;

    logic [NUM_CU:0] src_vec;
    logic            req, coll_now;
    logic [DW-1:0]   sel_dt;
    logic            w_en_d, w_en_q, coll_d, coll_q, stky_d, stky_q;
    logic [AW-1:0]   wadd_d, wadd_q;
    logic [DW-1:0]   dt_d, dt_q;

    // fixed-priority select bc > CU0 > CU1 > ...; clearing the lowest set bit exposes a second request
    always_comb begin
        src_vec  = {ps_xb_w_cuEn, ps_xb_w_bcEn};
        req      = |src_vec;
        coll_now = |(src_vec & (src_vec - (NUM_CU + 1)'(1)));
        sel_dt   = '0;
        for (int i = NUM_CU - 1; i >= SRC_ALU; i--)
            sel_dt = ps_xb_w_cuEn[i] ? cu_xb_dt[i*DW +: DW] : sel_dt;
        sel_dt   = ps_xb_w_bcEn ? bc_dt : sel_dt;
    end

    // WB stage is reloaded every cycle; the collision flag is sticky
    always_comb begin
        w_en_d = req;
        wadd_d = ps_xb_wadd;
        dt_d   = req ? sel_dt : '0;
        coll_d = coll_now;
        stky_d = stky_q | coll_now;
    end

    // WB and collision registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            w_en_q <= 1'b0;
            wadd_q <= '0;
            dt_q   <= '0;
            coll_q <= 1'b0;
            stky_q <= 1'b0;
        end else begin
            w_en_q <= w_en_d;
            wadd_q <= wadd_d;
            dt_q   <= dt_d;
            coll_q <= coll_d;
            stky_q <= stky_d;
        end
    end

    assign xb_rf_w_En   = w_en_q;
    assign xb_rf_wadd   = wadd_q;
    assign xb_rf_dt     = dt_q;
    assign xb_coll      = coll_q;
    assign xb_coll_stky = stky_q;

`ifdef XB_COLL_CNT_EN
    logic [COLL_CNT_W-1:0] cnt_d, cnt_q;

    // saturating count of collision cycles
    always_comb cnt_d = (coll_now && cnt_q != '1) ? cnt_q + COLL_CNT_W'(1) : cnt_q;

    // collision counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign xb_coll_cnt = cnt_q;
`endif

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        cu_xb_fwd #(.DW(DW), .AW(AW)) u_fwd (
            .radd    (ps_xb_radd[r*AW +: AW]),
            .req     (req),
            .wadd    (ps_xb_wadd),
            .sel_dt  (sel_dt),
            .wb_en   (w_en_q),
            .wb_wadd (wadd_q),
            .wb_dt   (dt_q),
            .rf_dt   (rf_xb_dt[r*DW +: DW]),
            .dt      (xb_dt[r*DW +: DW])
        );
    end
endmodule

// File: tb/tb_cu_xb_pipe.sv
// tb_cu_xb_pipe: directed self-checking bench for cu_xb_pipe (XB_COLL_CNT_EN enables counter checks)
module tb_cu_xb_pipe;
    import cu_xb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cu_en;
    logic        bc_en;
    logic [3:0]  wadd;
    logic [47:0] cu_dt;
    logic [15:0] bc_dt;
    logic [7:0]  radd;
    logic [31:0] rf_dt;
    logic [31:0] xb_dt;
    logic        w_en;
    logic [3:0]  rf_wadd;
    logic [15:0] rf_wdt;
    logic        coll, stky;
    int          total = 0;
    int          bad = 0;
`ifdef XB_COLL_CNT_EN
    logic [15:0] cnt;
`endif

    cu_xb_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .ps_xb_w_cuEn (cu_en),
        .ps_xb_w_bcEn (bc_en),
        .ps_xb_wadd   (wadd),
        .cu_xb_dt     (cu_dt),
        .bc_dt        (bc_dt),
        .ps_xb_radd   (radd),
        .rf_xb_dt     (rf_dt),
        .xb_dt        (xb_dt),
        .xb_rf_w_En   (w_en),
        .xb_rf_wadd   (rf_wadd),
        .xb_rf_dt     (rf_wdt),
        .xb_coll      (coll),
        .xb_coll_stky (stky)
`ifdef XB_COLL_CNT_EN
        ,
        .xb_coll_cnt  (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cu(input int i, input logic [15:0] v);
        cu_dt[i*16 +: 16] = v;
    endtask

    initial begin
        reset = 1'b1; cu_en = 3'b001; bc_en = 1'b0; wadd = 4'd1;
        cu_dt = '0; bc_dt = '0; radd = '0; rf_dt = {16'h9999, 16'h8888};
        set_cu(SRC_ALU, 16'h1234);
        tick();
        check("rst_wen", w_en, 0);
        check("rst_dt", rf_wdt, 0);
        check("rst_wadd", rf_wadd, 0);
        check("rst_coll", coll, 0);
        check("rst_stky", stky, 0);
`ifdef XB_COLL_CNT_EN
        check("rst_cnt", cnt, 0);
`endif
        reset = 1'b0; cu_en = 3'b000;
        tick();
        check("post_rst_wen", w_en, 0);

        cu_en = 3'b010; wadd = 4'd5; set_cu(SRC_MUL, 16'hBEEF);
        tick();
        check("mul_wen", w_en, 1);
        check("mul_wadd", rf_wadd, 5);
        check("mul_dt", rf_wdt, 16'hBEEF);
        check("mul_coll", coll, 0);
        cu_en = 3'b000;
        tick();
        check("idle_wen", w_en, 0);
        check("idle_dt", rf_wdt, 0);

        cu_en = 3'b001; wadd = 4'd3; set_cu(SRC_ALU, 16'h1111); radd = {4'd3, 4'd3};
        #1;
        check("fwd_new_p0", xb_dt[15:0], 16'h1111);
        check("fwd_new_p1", xb_dt[31:16], 16'h1111);
        tick();
        cu_en = 3'b000;
        #1;
        check("fwd_wb_p0", xb_dt[15:0], 16'h1111);
        check("fwd_wb_p1", xb_dt[31:16], 16'h1111);
        tick();
        #1;
        check("pass_p0", xb_dt[15:0], 16'h8888);
        check("pass_p1", xb_dt[31:16], 16'h9999);

        cu_en = 3'b001; wadd = 4'd7; set_cu(SRC_ALU, 16'hAAAA); radd = {4'd2, 4'd7};
        #1;
        check("b2b_t_p0", xb_dt[15:0], 16'hAAAA);
        check("b2b_t_p1", xb_dt[31:16], 16'h9999);
        tick();
        check("b2b_wb1", rf_wdt, 16'hAAAA);
        cu_en = 3'b100; set_cu(SRC_SHF, 16'h5555);
        #1;
        check("b2b_t1_p0", xb_dt[15:0], 16'h5555);
        tick();
        check("b2b_wb2", rf_wdt, 16'h5555);
        check("b2b_wadd", rf_wadd, 7);
        cu_en = 3'b000;
        #1;
        check("b2b_wbfwd", xb_dt[15:0], 16'h5555);
        tick();
        #1;
        check("b2b_pass", xb_dt[15:0], 16'h8888);

        bc_en = 1'b1; cu_en = 3'b101; bc_dt = 16'h00C3; wadd = 4'd2;
        #1;
        check("bc_fwd_p1", xb_dt[31:16], 16'h00C3);
        tick();
        check("bc_dt", rf_wdt, 16'h00C3);
        check("bc_coll", coll, 1);
        check("bc_stky", stky, 1);
`ifdef XB_COLL_CNT_EN
        check("bc_cnt", cnt, 1);
`endif
        bc_en = 1'b0; cu_en = 3'b000;
        tick();
        check("coll_pulse", coll, 0);
        check("stky_hold", stky, 1);

        cu_en = 3'b011; set_cu(SRC_ALU, 16'h1111); set_cu(SRC_MUL, 16'h2222);
        tick();
        check("cu_prio_dt", rf_wdt, 16'h1111);
        check("cu_coll", coll, 1);
`ifdef XB_COLL_CNT_EN
        check("cu_cnt", cnt, 2);
`endif
        cu_en = 3'b000; reset = 1'b1;
        tick();
        check("rst_stky_clr", stky, 0);
        reset = 1'b0;

`ifdef XB_COLL_CNT_EN
        cu_en = 3'b110;
        for (int k = 0; k < 16'hFFFE; k++) tick();
        check("sat_fffe", cnt, 16'hFFFE);
        tick();
        check("sat_ffff", cnt, 16'hFFFF);
        tick();
        check("sat_hold", cnt, 16'hFFFF);
        cu_en = 3'b000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
